// File: rtl/booth_multiplier_seq.sv
// Iterative radix-4 Booth multiplier that retires one Booth digit per clock.
// Signed/unsigned per operation, valid/ready on both sides, result held under backpressure.
//
// state  | meaning
// IDLE   | waiting for a request
// BUSY   | retiring one Booth digit per clock, COUNT cycles
// DONE   | product valid, held until out_ready
module booth_multiplier_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_result,
    output logic                 busy
);
    localparam int COUNT = WIDTH / 2 + 1;
    localparam int HW    = WIDTH + 3;
    localparam int LW    = 2 * COUNT;
    localparam int BW    = 2 * COUNT + 1;
    localparam int PW    = 2 * WIDTH;
    localparam int CW    = $clog2(COUNT);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]     state_q, state_d;
    logic [WIDTH:0] a_q, a_d;
    logic [BW-1:0]  b_q, b_d;
    logic [HW-1:0]  hi_q, hi_d;
    logic [LW-3:0]  lo_q, lo_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [PW-1:0]  res_q, res_d;

    logic [WIDTH:0] a_ext, b_ext;
    logic [BW-1:0]  b_init;
    logic [HW-1:0]  a_se, a_x2, addend, sum, hi_shift;
    logic [LW-1:0]  lo_shift;
    logic [BW-1:0]  b_shift;
    logic           cin;
    logic           accept;

    assign in_ready   = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
    assign out_valid  = (state_q == S_DONE);
    assign busy       = (state_q == S_BUSY);
    assign out_result = res_q;
    assign accept     = in_valid & in_ready;

    always_comb begin
        a_ext  = {in_signed & in_a[WIDTH-1], in_a};
        b_ext  = {in_signed & in_b[WIDTH-1], in_b};
        b_init = {BW{b_ext[WIDTH]}};
        b_init[WIDTH+1:0] = {b_ext, 1'b0};
    end

    // The high accumulator slice is the only adder; retired low bits shift into lo.
    always_comb begin
        a_se = {HW{a_q[WIDTH]}};
        a_se[WIDTH:0] = a_q;
        a_x2   = a_se << 1;
        addend = '0;
        cin    = 1'b0;
        case (b_q[2:0])
            3'b001, 3'b010: addend = a_se;
            3'b011:         addend = a_x2;
            3'b100:         begin addend = ~a_x2; cin = 1'b1; end
            3'b101, 3'b110: begin addend = ~a_se; cin = 1'b1; end
            default:        addend = '0;
        endcase
        sum      = hi_q + addend + {{(HW-1){1'b0}}, cin};
        hi_shift = {sum[HW-1], sum[HW-1], sum[HW-1:2]};
        lo_shift = {sum[1:0], lo_q};
        b_shift  = {b_q[BW-1], b_q[BW-1], b_q[BW-1:2]};
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        case (state_q)
            S_BUSY: begin
                hi_d = hi_shift;
                lo_d = lo_shift[LW-1:2];
                b_d  = b_shift;
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    res_d   = PW'({hi_shift, lo_shift});
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DONE: begin
                if (out_ready && !in_valid) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (accept) begin
            state_d = S_BUSY;
            a_d     = a_ext;
            b_d     = b_init;
            hi_d    = '0;
            lo_d    = '0;
            cnt_d   = CW'(COUNT - 1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end
endmodule

// File: tb/tb_booth_multiplier_seq.sv
// Directed and randomized checks of booth_multiplier_seq at WIDTH=8 and WIDTH=7.
module tb_booth_multiplier_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        i8_valid = 1'b0, i8_ready, i8_signed = 1'b0;
    logic [7:0]  i8_a = '0, i8_b = '0;
    logic        o8_valid, o8_ready = 1'b1, busy8;
    logic [15:0] o8_result;

    logic        i7_valid = 1'b0, i7_ready, i7_signed = 1'b0;
    logic [6:0]  i7_a = '0, i7_b = '0;
    logic        o7_valid, o7_ready = 1'b1, busy7;
    logic [13:0] o7_result;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    booth_multiplier_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(i8_valid), .in_ready(i8_ready), .in_a(i8_a), .in_b(i8_b), .in_signed(i8_signed),
        .out_valid(o8_valid), .out_ready(o8_ready), .out_result(o8_result), .busy(busy8)
    );

    booth_multiplier_seq #(.WIDTH(7)) dut7 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(i7_valid), .in_ready(i7_ready), .in_a(i7_a), .in_b(i7_b), .in_signed(i7_signed),
        .out_valid(o7_valid), .out_ready(o7_ready), .out_result(o7_result), .busy(busy7)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b, input logic s);
        int ia, ib;
        logic [31:0] p;
        ia = s ? int'($signed(a)) : int'(a);
        ib = s ? int'($signed(b)) : int'(b);
        p  = ia * ib;
        return p[15:0];
    endfunction

    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic s);
        for (int k = 0; k < 50 && !i8_ready; k++) tick();
        chk("issue8_ready", {31'd0, i8_ready}, 32'd1);
        i8_a = a; i8_b = b; i8_signed = s; i8_valid = 1'b1;
        tick();
        i8_valid = 1'b0;
    endtask

    task automatic wait8(input logic [15:0] exp, input string tag);
        int lat, bsy;
        lat = 0;
        bsy = busy8 ? 1 : 0;
        while (!o8_valid && lat < 20) begin
            tick();
            lat++;
            if (busy8) bsy++;
        end
        chk({tag, "_lat"}, lat, 5);
        chk({tag, "_busy"}, bsy, 5);
        chk({tag, "_res"}, {16'd0, o8_result}, {16'd0, exp});
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                       input logic [15:0] exp, input string tag);
        issue8(a, b, s);
        wait8(exp, tag);
    endtask

    task automatic op7(input logic [6:0] a, input logic [6:0] b, input logic s,
                       input logic [13:0] exp, input string tag);
        int lat;
        for (int k = 0; k < 50 && !i7_ready; k++) tick();
        i7_a = a; i7_b = b; i7_signed = s; i7_valid = 1'b1;
        tick();
        i7_valid = 1'b0;
        lat = 0;
        while (!o7_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, "_lat"}, lat, 4);
        chk({tag, "_res"}, {18'd0, o7_result}, {18'd0, exp});
    endtask

    task automatic random8(input int n_ops);
        logic [15:0] q[$];
        logic [15:0] e;
        logic        req;
        int          issued, got;
        req = 1'b0; issued = 0; got = 0;
        for (int cyc = 0; cyc < 20000 && got < n_ops; cyc++) begin
            tick();
            o8_ready = ($urandom_range(0, 3) != 0);
            if (!req && issued < n_ops && $urandom_range(0, 2) != 0) begin
                i8_a      = 8'($urandom_range(0, 255));
                i8_b      = 8'($urandom_range(0, 255));
                i8_signed = 1'($urandom_range(0, 1));
                req       = 1'b1;
            end
            i8_valid = req;
            #1;
            if (o8_valid && o8_ready) begin
                if (q.size() == 0) begin
                    chk("rnd_spurious", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("rnd_res", {16'd0, o8_result}, {16'd0, e});
                end
                got++;
            end
            if (i8_valid && i8_ready) begin
                q.push_back(model8(i8_a, i8_b, i8_signed));
                req = 1'b0;
                issued++;
            end
        end
        chk("rnd_count", got, n_ops);
        chk("rnd_leftover", q.size(), 0);
        tick();
        i8_valid = 1'b0;
        o8_ready = 1'b1;
    endtask

    initial begin
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_out_valid", {31'd0, o8_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy8}, 32'd0);
        chk("rst_result", {16'd0, o8_result}, 32'd0);
        chk("rst_in_ready", {31'd0, i8_ready}, 32'd1);

        op8(8'hFF, 8'hFF, 1'b0, 16'hFE01, "u_ff_ff");
        op8(8'h80, 8'h80, 1'b1, 16'h4000, "s_80_80");
        op8(8'hFF, 8'h01, 1'b1, 16'hFFFF, "s_ff_01");
        op8(8'h7F, 8'h80, 1'b1, 16'hC080, "s_7f_80");
        op8(8'hFF, 8'h01, 1'b0, 16'h00FF, "u_ff_01");
        op8(8'h00, 8'h80, 1'b1, 16'h0000, "s_00_80");
        tick();

        // Backpressure: result held, new request ignored, then back-to-back transfer.
        o8_ready = 1'b0;
        op8(8'h12, 8'h34, 1'b0, 16'h03A8, "bp");
        i8_a = 8'h03; i8_b = 8'h05; i8_signed = 1'b0; i8_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("bp_hold_res", {16'd0, o8_result}, 32'h03A8);
            chk("bp_hold_ready", {31'd0, i8_ready}, 32'd0);
            chk("bp_hold_valid", {31'd0, o8_valid}, 32'd1);
        end
        o8_ready = 1'b1;
        #1;
        chk("bp_release_ready", {31'd0, i8_ready}, 32'd1);
        tick();
        i8_valid = 1'b0;
        chk("bp_b2b_valid", {31'd0, o8_valid}, 32'd0);
        wait8(16'h000F, "bp_next");
        tick();

        // Reset in the middle of an operation.
        issue8(8'h55, 8'h66, 1'b0);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_out_valid", {31'd0, o8_valid}, 32'd0);
        chk("midrst_busy", {31'd0, busy8}, 32'd0);
        chk("midrst_result", {16'd0, o8_result}, 32'd0);
        chk("midrst_in_ready", {31'd0, i8_ready}, 32'd1);
        op8(8'h0A, 8'h0B, 1'b0, 16'h006E, "post_rst");
        tick();

        op7(7'h7F, 7'h7F, 1'b0, 14'h3F01, "w7_u_7f_7f");
        op7(7'h40, 7'h3F, 1'b1, 14'h3040, "w7_s_40_3f");
        op7(7'h7F, 7'h7F, 1'b1, 14'h0001, "w7_s_7f_7f");
        op7(7'h40, 7'h40, 1'b1, 14'h1000, "w7_s_40_40");
        op7(7'h40, 7'h40, 1'b0, 14'h1000, "w7_u_40_40");
        tick();

        random8(300);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
